iter_div: RTL and testbench
===========================

ITER_DIV -- requirements
Module: iter_div

Interface
REQ-001 The block SHALL have no parameters; width is fixed at 32-bit operands and 64-bit result.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 signed_div  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start in IDLE.
REQ-005 opdata1  input  32  dividend; sampled with start in IDLE.
REQ-006 opdata2  input  32  divisor; sampled with start in IDLE.
REQ-007 div_start  input  1  request from the hazard unit; held high while the EX instruction is DIV/DIVU and div_ready is 0.
REQ-008 annul  input  1  EX flush (exception); cancels any operation in progress.
REQ-009 div_result  output  64  {remainder[63:32], quotient[31:0]}, i.e. {HI, LO}.
REQ-010 div_ready  output  1  result valid; single-cycle pulse.

Function
REQ-011 States SHALL be IDLE, DIVZERO, ON and END; the iteration counter SHALL be 6 bits.
REQ-012 IDLE: if div_start=1 and annul=0, latch operands; if divisor=0, go to DIVZERO, otherwise go to ON with counter=0; otherwise remain in IDLE.
REQ-013 Signed mode SHALL latch absolute values of the operands (two's complement negation) and record sign(quotient)=s1^s2 and sign(remainder)=s1.
REQ-014 ON SHALL perform one restoring radix-2 step per cycle on a 65-bit {partial remainder, dividend} register: trial subtract of the divisor from the top 33 bits; shift in 1 if non-negative, else shift in 0.
REQ-015 After 32 ON cycles (counter 0..31), the next state SHALL be END.
REQ-016 On entry to END, the quotient and remainder SHALL be sign-corrected in signed mode and loaded into div_result.
REQ-017 DIVZERO SHALL take one cycle, load div_result=64'h0, and go to END.
REQ-018 END SHALL drive div_ready=1 for exactly one cycle and then go to IDLE unconditionally.
REQ-019 Latency: with div_start first high in IDLE at cycle 0, div_ready SHALL be high in cycle 33 for a nonzero divisor and in cycle 2 for a zero divisor.
REQ-020 In ON or DIVZERO, if annul=1 or div_start=0, the next state SHALL be IDLE, div_ready SHALL remain 0, and div_result SHALL be left unchanged.
REQ-021 A div_start that is still high in the cycle after END SHALL be treated as a new request, because the hazard unit deasserts div_start combinationally while div_ready=1.
REQ-022 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give quotient 0x80000000 and remainder 0, with no trap.
REQ-023 div_result SHALL hold its last value until the next END or reset.
REQ-024 div_ready SHALL be a registered output, decoded from state END, with no combinational path from any input.

Reset
REQ-025 While rst=1, on the next rising edge the block SHALL enter IDLE with counter=0, div_ready=0, div_result=64'h0 and all latched operand and sign state cleared.
REQ-026 Reset SHALL override annul and div_start, and an operation in progress SHALL be abandoned without asserting div_ready.

Verification
REQ-027 Unsigned 100/7 (start held until ready): div_ready=1 in cycle 33; div_result={32'h2, 32'hE}.
REQ-028 Signed -7/2 (0xFFFFFFF9, 0x2): cycle 33 div_result={32'hFFFFFFFF, 32'hFFFFFFFD}.
REQ-029 Signed 5/0: div_ready=1 in cycle 2; div_result=64'h0; the block is IDLE in cycle 3.
REQ-030 Unsigned 0xFFFFFFFF/3 with annul=1 in cycle 10: the block is IDLE in cycle 11; div_ready stays 0 through cycle 40; div_result is unchanged.
REQ-031 Signed 0x80000000/0xFFFFFFFF: cycle 33 div_result={32'h0, 32'h80000000}.
REQ-032 rst=1 in cycle 15 of a divide, then a new start of 9/4 issued in cycle 17: div_ready in cycle 50 with div_result={32'h1, 32'h2}, and no ready pulse before that.

Source files
------------

// File: rtl/iter_div.sv
// Iterative 32/32 integer divider (DIV/DIVU): one restoring radix-2 step per
// cycle, result packed as {remainder, quotient} with a one-cycle ready pulse.
module iter_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        div_start,
  input  logic        annul,
  output logic [63:0] div_result,
  output logic        div_ready
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DIVZERO = 2'd1;
  localparam logic [1:0] S_ON      = 2'd2;
  localparam logic [1:0] S_END     = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] acc_q, acc_d;
  logic [31:0] divisor_q, divisor_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic [63:0] result_q, result_d;

  logic [32:0] trial;
  logic        fits;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [64:0] acc_step;

  function automatic logic [31:0] abs32(input logic signed [31:0] v, input logic en);
    logic [31:0] r;
    r = v;
    if (en && v[31]) r = ~v + 32'd1;
    return r;
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

  // acc_q holds the already-shifted partial remainder in [64:32], so its LSB is
  // the next dividend bit; quotient bits shift in at bit 0.
  always_comb begin
    trial    = acc_q[64:32] - {1'b0, divisor_q};
    fits     = ~trial[32];
    rem_next = fits ? trial[31:0] : acc_q[63:32];
    quo_next = {acc_q[30:0], fits};
    acc_step = {rem_next, acc_q[31:0], fits};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    divisor_d = divisor_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (div_start && !annul) begin
          divisor_d = abs32(opdata2, signed_div);
          acc_d     = {32'd0, abs32(opdata1, signed_div), 1'b0};
          q_neg_d   = signed_div & (opdata1[31] ^ opdata2[31]);
          r_neg_d   = signed_div & opdata1[31];
          cnt_d     = 6'd0;
          state_d   = (opdata2 == 32'd0) ? S_DIVZERO : S_ON;
        end
      end
      S_DIVZERO: begin
        if (annul || !div_start) begin
          state_d = S_IDLE;
        end else begin
          result_d = 64'd0;
          state_d  = S_END;
        end
      end
      S_ON: begin
        if (annul || !div_start) begin
          state_d = S_IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            result_d = {neg_if(rem_next, r_neg_q), neg_if(quo_next, q_neg_q)};
            state_d  = S_END;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      acc_q     <= 65'd0;
      divisor_q <= 32'd0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      result_q  <= 64'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      divisor_q <= divisor_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      result_q  <= result_d;
    end
  end

  assign div_result = result_q;
  assign div_ready  = (state_q == S_END);

endmodule

// File: tb/tb_iter_div.sv
// Bench for iter_div: directed corner cases plus randomized operands checked
// against an arithmetic reference model.
module tb_iter_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        div_start;
  logic        annul;
  logic [63:0] div_result;
  logic        div_ready;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] last_exp = 64'd0;

  iter_div dut (
    .clk        (clk),
    .rst        (rst),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .div_start  (div_start),
    .annul      (annul),
    .div_result (div_result),
    .div_ready  (div_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Truncating division on 64-bit integers; divide-by-zero yields 0.
  function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == 32'd0) return 64'd0;
    sa = sg ? {{32{a[31]}}, a} : {32'd0, a};
    sb = sg ? {{32{b[31]}}, b} : {32'd0, b};
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  // Called at the negedge of cycle 0; returns at the negedge after the ready cycle.
  task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] exp;
    int          lat;
    int          exp_lat;
    exp     = model(sg, a, b);
    exp_lat = (b == 32'd0) ? 2 : 33;
    signed_div = sg;
    opdata1    = a;
    opdata2    = b;
    div_start  = 1'b1;
    lat        = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (div_ready) begin
        lat = c;
        break;
      end
    end
    div_start = 1'b0;
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, div_result, exp);
    last_exp = exp;
    @(negedge clk);
    check({tag, "_pulse"}, {63'd0, div_ready}, 64'd0);
    check({tag, "_hold"}, div_result, exp);
  endtask

  initial begin
    int          seen;
    int          lat;
    logic        sg;
    logic [31:0] a, b;

    rst = 1'b1; div_start = 1'b0; annul = 1'b0;
    signed_div = 1'b0; opdata1 = 32'd0; opdata2 = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_ready", {63'd0, div_ready}, 64'd0);
    check("reset_result", div_result, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_div(1'b0, 32'd100, 32'd7, "u100_7");
    check("u100_7_const", div_result, {32'h2, 32'hE});
    run_div(1'b1, 32'hFFFFFFF9, 32'h2, "s_m7_2");
    check("s_m7_2_const", div_result, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_div(1'b1, 32'd5, 32'd0, "s5_0");
    check("s5_0_const", div_result, 64'd0);
    // Starts in cycle 3 of the previous operation: block must already be idle.
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, "s_ovf");
    check("s_ovf_const", div_result, {32'h0, 32'h80000000});

    // Annul in cycle 10, request withdrawn: no result ever appears.
    signed_div = 1'b0; opdata1 = 32'hFFFFFFFF; opdata2 = 32'd3; div_start = 1'b1;
    seen = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (div_ready) seen = 1;
      if (c == 10) annul = 1'b1;
      if (c == 11) begin annul = 1'b0; div_start = 1'b0; end
    end
    check("annul_noready", 64'(seen), 64'd0);
    check("annul_hold", div_result, last_exp);

    // Annul in cycle 10 with the request still pending: restarts from idle in cycle 11.
    div_start = 1'b1;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (div_ready) begin lat = c; break; end
      if (c == 10) annul = 1'b1;
      if (c == 11) annul = 1'b0;
    end
    div_start = 1'b0;
    check("annul_restart_lat", 64'(lat), 64'd44);
    check("annul_restart_res", div_result, model(1'b0, 32'hFFFFFFFF, 32'd3));
    check("annul_restart_const", div_result, {32'h0, 32'h55555555});
    last_exp = div_result === {32'h0, 32'h55555555} ? div_result : {32'h0, 32'h55555555};
    @(negedge clk);

    // Reset in cycle 15 while start is held, then 9/4 from cycle 17.
    signed_div = 1'b0; opdata1 = 32'hFFFFFFFF; opdata2 = 32'd3; div_start = 1'b1;
    seen = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (div_ready) seen = 1;
      if (c == 15) rst = 1'b1;
      if (c == 16) begin rst = 1'b0; div_start = 1'b0; end
    end
    check("rst_mid_noready", 64'(seen), 64'd0);
    check("rst_mid_result", div_result, 64'd0);
    @(negedge clk);
    run_div(1'b0, 32'd9, 32'd4, "rst_9_4");
    check("rst_9_4_const", div_result, {32'h1, 32'h2});

    // Zero divisor with the request dropped after one cycle.
    signed_div = 1'b0; opdata1 = 32'd17; opdata2 = 32'd0; div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (div_ready) seen = 1;
    end
    check("dz_abort_noready", 64'(seen), 64'd0);
    check("dz_abort_hold", div_result, last_exp);

    for (int i = 0; i < 24; i++) begin
      sg = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFFFFFF;
        3:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      run_div(sg, a, b, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
